// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse transmitter.
// State encoding and unit counts per state.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        CGAP,
        WGAP
    } state_e;

    localparam int DOT_UNITS        = 1;
    localparam int DASH_UNITS       = 3;
    localparam int SYM_GAP_UNITS    = 1;
    localparam int CHAR_GAP_UNITS   = 3;
    localparam int WORD_EXTRA_UNITS = 4;

    // Units spent in a state, minus one, as loaded at state entry
    function automatic logic [2:0] units_m1(state_e s, logic dash);
        case (s)
            MARK:    return dash ? 3'(DASH_UNITS - 1) : 3'(DOT_UNITS - 1);
            GAP:     return 3'(SYM_GAP_UNITS - 1);
            CGAP:    return 3'(CHAR_GAP_UNITS - 1);
            WGAP:    return 3'(WORD_EXTRA_UNITS - 1);
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/morse_tx_engine_if.sv
// Character input handshake bundle.
// Master offers code/len with valid; slave answers ready.
interface morse_tx_engine_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
);
    logic [MAX_LEN-1:0] in_code;
    logic [LEN_W-1:0]   in_len;
    logic               in_valid;
    logic               in_ready;

    modport master (
        output in_code,
        output in_len,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_code,
        input  in_len,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/morse_char_fifo.sv
// Small synchronous FIFO holding queued characters.
// Flush empties it in one edge; pointers wrap modulo DEPTH.
module morse_char_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and occupancy update; flush wins over push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/morse_tx_engine.sv
// Buffered Morse transmitter: FIFO feeding a timed key FSM.
// Each state lasts a whole number of units of max(unit_period,1) clocks.
module morse_tx_engine
    import morse_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int DEPTH   = 4,
    parameter int UNIT_W  = 27
) (
    input  logic                clk,
    input  logic                rst,
    morse_tx_engine_if.slave    in_if,
    input  logic [UNIT_W-1:0]   unit_period,
    input  logic                abort,
    output logic                key,
    output logic                char_done,
    output logic                busy,
    output logic [LEN_W:0]      fifo_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int WIDTH = MAX_LEN + LEN_W;

    logic               push, pop, full, empty;
    logic [WIDTH-1:0]   rdata;
    logic [AW:0]        cnt;
    logic [MAX_LEN-1:0] pop_code, pop_shift;
    logic [LEN_W-1:0]   pop_len, pop_len_c;

    state_e             state_q, state_d;
    logic [UNIT_W-1:0]  tick_q, tick_d;
    logic [UNIT_W-1:0]  period_q, period_d;
    logic [2:0]         units_q, units_d;
    logic [MAX_LEN-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               key_q, key_d;
    logic               done, enter, exit_c;

    assign push = in_if.in_valid && in_if.in_ready && !abort;
    assign in_if.in_ready = !full;
    assign fifo_count = (LEN_W+1)'(cnt);

    morse_char_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .wdata ({in_if.in_code, in_if.in_len}),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (cnt)
    );

    // Clamp length on pop and left-align the code so the MSB is sent first
    assign pop_code  = rdata[WIDTH-1:LEN_W];
    assign pop_len   = rdata[LEN_W-1:0];
    assign pop_len_c = (pop_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pop_len;
    assign pop_shift = pop_code << (LEN_W'(MAX_LEN) - pop_len_c);

    assign done = (tick_q == period_q - UNIT_W'(1)) && (units_q == 3'd0);

    // Next-state, counters and pop control
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        period_d = period_q;
        units_d  = units_q;
        shift_d  = shift_q;
        rem_d    = rem_q;
        pop      = 1'b0;
        enter    = 1'b0;
        exit_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    enter = 1'b1;
                end
            end
            MARK: begin
                if (done) begin
                    enter   = 1'b1;
                    state_d = (rem_q > LEN_W'(1)) ? GAP : CGAP;
                end
            end
            GAP: begin
                if (done) begin
                    enter   = 1'b1;
                    state_d = MARK;
                    shift_d = shift_q << 1;
                    rem_d   = rem_q - LEN_W'(1);
                end
            end
            CGAP, WGAP: begin
                if (done) begin
                    exit_c = 1'b1;
                    enter  = 1'b1;
                    if (!empty) pop = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = pop_shift;
            rem_d   = pop_len_c;
            state_d = (pop_len_c != '0) ? MARK : WGAP;
        end
        if (enter) begin
            period_d = (unit_period == '0) ? UNIT_W'(1) : unit_period;
            tick_d   = '0;
            units_d  = units_m1(state_d, shift_d[MAX_LEN-1]);
        end else if (state_q != IDLE) begin
            if (tick_q == period_q - UNIT_W'(1)) begin
                tick_d  = '0;
                units_d = units_q - 3'd1;
            end else begin
                tick_d = tick_q + UNIT_W'(1);
            end
        end
        key_d = (state_d == MARK);
        if (abort) begin
            state_d = IDLE;
            key_d   = 1'b0;
            pop     = 1'b0;
            tick_d  = '0;
            units_d = '0;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            period_q <= UNIT_W'(1);
            units_q  <= '0;
            shift_q  <= '0;
            rem_q    <= '0;
            key_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            units_q  <= units_d;
            shift_q  <= shift_d;
            rem_q    <= rem_d;
            key_q    <= key_d;
        end
    end

    assign key       = key_q;
    assign char_done = exit_c && !abort && !rst;
    assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_morse_tx_engine.sv
// Scoreboard bench for morse_tx_engine.
// Expected key waveforms are built from Morse timing rules per accepted char.
module tb_morse_tx_engine;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int DEPTH   = 4;
    localparam int UNIT_W  = 27;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              abort = 1'b0;
    logic [UNIT_W-1:0] unit_period = 1;
    logic              key, char_done, busy;
    logic [LEN_W:0]    fifo_count;

    morse_tx_engine_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) in_if ();

    morse_tx_engine #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DEPTH(DEPTH), .UNIT_W(UNIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (in_if),
        .unit_period (unit_period),
        .abort       (abort),
        .key         (key),
        .char_done   (char_done),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit exp_bits[$];
    int exp_len[$];
    bit hist[$];
    bit idle_start = 1'b1;
    int bcnt = 0;
    int max_cnt = 0;

    function automatic void chk(bit ok, string name, int act, int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Reference: key waveform of one character from dot/dash/gap unit rules
    function automatic void model_push(logic [7:0] code, int len, int p);
        int u = (p == 0) ? 1 : p;
        int n = (len > MAX_LEN) ? MAX_LEN : len;
        int l = 0;
        if (n == 0) begin
            repeat (4 * u) exp_bits.push_back(1'b0);
            l = 4 * u;
        end else begin
            for (int i = n - 1; i >= 0; i--) begin
                int m = code[i] ? 3 : 1;
                repeat (m * u) exp_bits.push_back(1'b1);
                l += m * u;
                if (i > 0) begin
                    repeat (u) exp_bits.push_back(1'b0);
                    l += u;
                end
            end
            repeat (3 * u) exp_bits.push_back(1'b0);
            l += 3 * u;
        end
        exp_len.push_back(l);
    endfunction

    function automatic void model_clear();
        exp_bits.delete();
        exp_len.delete();
        idle_start = 1'b1;
        bcnt = 0;
    endfunction

    // Monitor: on every char_done compare the trailing key window with the model
    always @(negedge clk) begin
        int l;
        int bad;
        int h;
        bit e;
        if (!rst) begin
            hist.push_back(key);
            if (hist.size() > 1000) void'(hist.pop_front());
            if (busy) bcnt++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            chk(in_if.in_ready == (int'(fifo_count) < DEPTH), "in_ready_vs_count",
                int'(in_if.in_ready), int'(fifo_count) < DEPTH);
            if (char_done) begin
                if (exp_len.size() == 0) begin
                    chk(1'b0, "spurious_char_done", 1, 0);
                end else begin
                    l = exp_len.pop_front();
                    bad = -1;
                    for (int i = 0; i < l; i++) begin
                        e = exp_bits.pop_front();
                        h = hist.size() - l + i;
                        if ((h < 0 || hist[h] != e) && bad < 0) bad = i;
                    end
                    chk(bad < 0, "key_pattern_first_bad_cycle", bad, -1);
                    chk(bcnt == l + int'(idle_start), "busy_span", bcnt, l + int'(idle_start));
                    idle_start = (exp_len.size() == 0);
                    bcnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] code, input int len);
        int g = 0;
        @(negedge clk);
        in_if.in_code  = code;
        in_if.in_len   = len[LEN_W-1:0];
        in_if.in_valid = 1'b1;
        while (!in_if.in_ready && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (!in_if.in_ready) begin
            chk(1'b0, "send_timeout", 0, 1);
            in_if.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_push(code, len, int'(unit_period));
            in_if.in_valid = 1'b0;
        end
    endtask

    task automatic lat_check();
        @(negedge clk);
        chk(key == 1'b0, "latency_pop_cycle_key", int'(key), 0);
        @(negedge clk);
        chk(key == 1'b1, "latency_key_on", int'(key), 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk(!busy, "idle_timeout", int'(busy), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int g;
        in_if.in_valid = 1'b0;
        in_if.in_code  = '0;
        in_if.in_len   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk(key == 1'b0, "reset_key", int'(key), 0);
        chk(char_done == 1'b0, "reset_char_done", int'(char_done), 0);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        chk(fifo_count == '0, "reset_fifo_count", int'(fifo_count), 0);
        chk(in_if.in_ready == 1'b1, "reset_in_ready", int'(in_if.in_ready), 1);

        // 'A' at four clocks per unit
        unit_period = 4;
        send(8'b01, 2);
        lat_check();
        g = 0;
        while (!char_done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk(char_done, "a_char_done_seen", int'(char_done), 1);
        @(negedge clk);
        chk(!busy, "a_busy_falls", int'(busy), 0);
        wait_idle();

        // Back-to-back 'E' 'E'
        unit_period = 2;
        send(8'h00, 1);
        send(8'h00, 1);
        wait_idle();

        // 'E' space 'E'
        unit_period = 1;
        send(8'h00, 1);
        send(8'h00, 0);
        send(8'h00, 1);
        wait_idle();

        // Overfill with valid held high
        max_cnt = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            c = 8'($urandom());
            send(c, int'($urandom_range(4, 8)));
        end
        wait_idle();
        chk(max_cnt == DEPTH, "fifo_reached_full", max_cnt, DEPTH);

        // Abort mid-dash with three queued, plus a push in the abort cycle
        unit_period = 2;
        send(8'hFF, 8);
        for (int i = 0; i < 3; i++) send(8'($urandom()), 3);
        @(negedge clk);
        chk(key == 1'b1, "abort_mid_dash_key", int'(key), 1);
        abort = 1'b1;
        in_if.in_valid = 1'b1;
        in_if.in_len   = 4'd1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        in_if.in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        chk(key == 1'b0, "abort_key", int'(key), 0);
        chk(fifo_count == '0, "abort_fifo_count", int'(fifo_count), 0);
        chk(busy == 1'b0, "abort_busy", int'(busy), 0);
        repeat (20) @(negedge clk);

        // Reset during a mark
        unit_period = 3;
        send(8'h01, 1);
        repeat (3) @(negedge clk);
        chk(key == 1'b1, "pre_reset_mark", int'(key), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk(key == 1'b0, "rst_key", int'(key), 0);
        chk(fifo_count == '0, "rst_fifo_count", int'(fifo_count), 0);
        chk(in_if.in_ready == 1'b1, "rst_in_ready", int'(in_if.in_ready), 1);
        send(8'h00, 1);
        lat_check();
        wait_idle();

        // Over-long length clamps to eight symbols
        unit_period = 1;
        send(8'hA5, 12);
        wait_idle();

        // Zero period behaves as one
        unit_period = 0;
        send(8'h03, 2);
        send(8'h02, 3);
        wait_idle();

        // Random traffic in batches of constant period
        for (int b = 0; b < 4; b++) begin
            unit_period = UNIT_W'($urandom_range(0, 3));
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(8'($urandom()), int'($urandom_range(0, 15)));
            end
            wait_idle();
        end

        chk(exp_len.size() == 0, "all_chars_sent", exp_len.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
